frame_assembler: RTL and testbench
==================================

# frame_assembler

Collects the bit stream delivered by the serial sync capturer (strobe/data/error) into a parallel frame and hands it to the print/display controller over a valid/ready handshake. Sits directly downstream of the capturer and upstream of the top-level print sequencer. It synchronises the capturer outputs into the system clock domain, counts payload bits, flags timeouts and capturer errors, and holds the finished frame until it is consumed.

## Interface
- WIDTH, 16, payload bits per frame (2..32)
- TIMEOUT, 50000000, sys_clk cycles with no strobe rising edge in COLLECT before declaring an error
- sys_clk  input  1  system clock; all logic on rising edge
- sys_rst  input  1  reset; synchronous and active-low, sampled on sys_clk rising edge
- strobe  input  1  bit strobe from capturer (div_clk domain, asynchronous here)
- data  input  1  bit value from capturer, valid while strobe rises
- error  input  1  capturer error flag, level
- start  input  1  one-cycle pulse (debounced key) arming a new frame
- frame_ready  input  1  consumer accepts frame
- frame_data  output  WIDTH  assembled frame, bit 0 = first bit received
- frame_valid  output  1  frame_data complete and stable
- frame_err  output  1  frame aborted (capturer error, timeout, or parity)
- busy  output  1  high in COLLECT
- state  output  2  FSM encoding, for LED display

## Operation
- Input sync: strobe, data, error each pass two flops; one more register holds previous synced strobe; edge = synced strobe high and previous low.
- States (state encoding): IDLE=00, COLLECT=01, HOLD=10, ERR=11.
- IDLE: start -> COLLECT; bit_cnt and frame_data cleared to 0, timeout counter cleared.
- COLLECT: on edge with bit_cnt < NBITS, frame_data[bit_cnt] <= synced data (parity bit goes to parity register when enabled), bit_cnt++, timeout counter cleared. On edge with bit_cnt == NBITS (terminating strobe): synced error high -> ERR, else parity check (if enabled) fails -> ERR, else -> HOLD. No edge for TIMEOUT consecutive cycles -> ERR. NBITS = WIDTH (or WIDTH+1 with parity).
- HOLD: frame_valid=1, frame_data frozen; frame_valid && frame_ready -> IDLE, frame_valid low next cycle. start ignored.
- ERR: frame_err=1; start -> COLLECT (re-armed as from IDLE), frame_err low next cycle. frame_data retains partial bits until restart.
- Simultaneous: start and edge in the same IDLE/ERR cycle -> start wins, edge discarded. Edge and timeout expiry in the same cycle -> edge wins. start in COLLECT restarts collection (counter and data cleared).
- Timeout counter width sized for TIMEOUT; saturates, no wrap.

## Timing
- Reset (sys_rst low at clock edge): state IDLE, frame_data 0, frame_valid 0, frame_err 0, busy 0, state 00, bit_cnt 0, sync flops 0. Reset mid-frame discards all progress.
- Strobe input rise to bit stored: 3 sys_clk cycles (2 sync + edge register); data and error follow the same path, so aligned.
- Terminating edge detected cycle N -> frame_valid or frame_err high from cycle N+1.
- Handshake: transfer on cycle where valid and ready both high; ready may be held high permanently; ready while not valid has no effect.
- start to busy high: 1 cycle.
- Strobe high time of at least 3 sys_clk cycles and low time of at least 3 required; narrower pulses may be missed.

## Configuration
- FRAME_PARITY_EN defined: NBITS = WIDTH+1; last received bit is even parity over the WIDTH payload bits (payload XOR parity must be 0); mismatch at terminating edge -> ERR. frame_data excludes parity bit.
- Not defined: NBITS = WIDTH, no parity register, ERR reached only via capturer error or timeout.

## Test plan
- Reset held 2 cycles mid-COLLECT -> all outputs 0, state 00 next cycle.
- start, 16 bits 1010_0000_1111_0011 (first bit first) + terminating strobe, error low -> frame_valid high, frame_data = 16'hCF05; ready after 5 cycles -> valid low, state 00.
- start, 8 edges then silence, TIMEOUT=100 -> frame_err high exactly 101 cycles after last edge detect, state 11; start -> state 01, frame_err low.
- Full frame with error high at terminating edge -> frame_err=1, frame_valid never high.
- FRAME_PARITY_EN: payload 16'h0001 with parity 1 -> HOLD; parity 0 -> ERR.
- start coincident with edge in IDLE -> bit_cnt stays 0; start pulses during HOLD -> frame_data unchanged, still valid.

Source files
------------

// File: rtl/frame_assembler.sv
// Assembles capturer bit strobes into a WIDTH-bit frame with a valid/ready handoff.
// Optional even parity bit after the payload is enabled by defining FRAME_PARITY_EN.
module frame_assembler #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 50000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             strobe,
  input  logic             data,
  input  logic             error,
  input  logic             start,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [1:0]       state
);

`ifdef FRAME_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    HOLD    = 2'b10,
    ERR     = 2'b11
  } state_t;

  state_t cur_state, next_state;

  logic strobe_s1, strobe_s2, strobe_prev;
  logic data_s1, data_s2;
  logic err_s1, err_s2;
  logic bit_edge;

  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             parity_fail;
  logic             clear_frame;
  logic             store_bit;

  // Capturer signals cross in through matched two-flop chains so data and error line up with the edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      strobe_s1   <= 1'b0;
      strobe_s2   <= 1'b0;
      strobe_prev <= 1'b0;
      data_s1     <= 1'b0;
      data_s2     <= 1'b0;
      err_s1      <= 1'b0;
      err_s2      <= 1'b0;
    end else begin
      strobe_s1   <= strobe;
      strobe_s2   <= strobe_s1;
      strobe_prev <= strobe_s2;
      data_s1     <= data;
      data_s2     <= data_s1;
      err_s1      <= error;
      err_s2      <= err_s1;
    end
  end

  assign bit_edge = strobe_s2 & ~strobe_prev;

`ifdef FRAME_PARITY_EN
  logic parity_bit;
  assign parity_fail = (^frame_data) ^ parity_bit;
`else
  assign parity_fail = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // start always beats a coincident edge; an edge beats a coincident timeout expiry.
  always_comb begin
    next_state  = cur_state;
    clear_frame = 1'b0;
    store_bit   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start) begin
          next_state  = COLLECT;
          clear_frame = 1'b1;
        end
      end
      COLLECT: begin
        if (start) begin
          clear_frame = 1'b1;
        end else if (bit_edge) begin
          if (bit_cnt < CNT_W'(NBITS)) begin
            store_bit = 1'b1;
          end else if (err_s2 || parity_fail) begin
            next_state = ERR;
          end else begin
            next_state = HOLD;
          end
        end else if (to_cnt >= TO_LAST) begin
          next_state = ERR;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          next_state = IDLE;
        end
      end
      ERR: begin
        if (start) begin
          next_state  = COLLECT;
          clear_frame = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      frame_data <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
`ifdef FRAME_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (clear_frame) begin
      frame_data <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
`ifdef FRAME_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (store_bit) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bit_cnt == CNT_W'(i)) begin
          frame_data[i] <= data_s2;
        end
      end
`ifdef FRAME_PARITY_EN
      if (bit_cnt == CNT_W'(WIDTH)) begin
        parity_bit <= data_s2;
      end
`endif
      bit_cnt <= bit_cnt + 1'b1;
      to_cnt  <= '0;
    end else if (cur_state == COLLECT && to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign frame_valid = (cur_state == HOLD);
  assign frame_err   = (cur_state == ERR);
  assign busy        = (cur_state == COLLECT);
  assign state       = cur_state;

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler (WIDTH=16, TIMEOUT=100); parity cases run only with FRAME_PARITY_EN.
module tb_frame_assembler;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 100;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             strobe;
  logic             data;
  logic             error;
  logic             start;
  logic             frame_ready;
  logic [WIDTH-1:0] frame_data;
  logic             frame_valid;
  logic             frame_err;
  logic             busy;
  logic [1:0]       state;

  int errors = 0;
  int checks = 0;
  logic valid_seen;

  frame_assembler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .strobe      (strobe),
    .data        (data),
    .error       (error),
    .start       (start),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .state       (state)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_valid) valid_seen <= 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic b);
    @(negedge sys_clk);
    data   = b;
    strobe = 1'b1;
    repeat (4) @(negedge sys_clk);
    strobe = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic pulseStart();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] payload, input logic par, input logic term_err);
    for (int i = 0; i < WIDTH; i++) applyStimulus(payload[i]);
`ifdef FRAME_PARITY_EN
    applyStimulus(par);
`endif
    error = term_err;
    applyStimulus(1'b0);
    error = 1'b0;
  endtask

  logic [15:0] pattern;
  logic [15:0] first_first;

  initial begin
    sys_rst     = 1'b0;
    strobe      = 1'b0;
    data        = 1'b0;
    error       = 1'b0;
    start       = 1'b0;
    frame_ready = 1'b0;
    valid_seen  = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_outputs", {frame_data, frame_valid, frame_err, busy}, 32'd0);
    sys_rst = 1'b1;

    // Main frame: bits listed first-first, so bit i of the frame is pattern[15-i].
    pattern = 16'b1010_0000_1111_0011;
    for (int i = 0; i < 16; i++) first_first[i] = pattern[15-i];
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    checkOutput("start_state", {30'd0, state}, 32'd1);
    sendFrame(first_first, ^first_first, 1'b0);
    checkOutput("frame_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("frame_data", {16'd0, frame_data}, 32'h0000CF05);
    checkOutput("hold_state", {30'd0, state}, 32'd2);
    pulseStart();
    pulseStart();
    checkOutput("hold_start_data", {16'd0, frame_data}, 32'h0000CF05);
    checkOutput("hold_start_valid", {31'd0, frame_valid}, 32'd1);
    repeat (5) @(negedge sys_clk);
    frame_ready = 1'b1;
    @(negedge sys_clk);
    frame_ready = 1'b0;
    checkOutput("handshake_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("handshake_state", {30'd0, state}, 32'd0);

    // Ready while not valid has no effect.
    frame_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    frame_ready = 1'b0;
    checkOutput("ready_idle_state", {30'd0, state}, 32'd0);

    // Timeout: 8 edges then silence; ERR is entered 101 cycles after the last edge-detect cycle.
    pulseStart();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1);
    @(negedge sys_clk);
    data   = 1'b1;
    strobe = 1'b1;
    repeat (2) @(negedge sys_clk);
    repeat (100) @(negedge sys_clk);
    strobe = 1'b0;
    checkOutput("timeout_early_err", {31'd0, frame_err}, 32'd0);
    checkOutput("timeout_early_state", {30'd0, state}, 32'd1);
    @(negedge sys_clk);
    checkOutput("timeout_err", {31'd0, frame_err}, 32'd1);
    checkOutput("timeout_state", {30'd0, state}, 32'd3);
    checkOutput("timeout_partial", {16'd0, frame_data}, 32'h000000FF);
    pulseStart();
    checkOutput("rearm_state", {30'd0, state}, 32'd1);
    checkOutput("rearm_err", {31'd0, frame_err}, 32'd0);

    // Capturer error at the terminating edge aborts the frame.
    valid_seen = 1'b0;
    sendFrame(16'hA5A5, ^16'hA5A5, 1'b1);
    repeat (2) @(negedge sys_clk);
    checkOutput("caperr_err", {31'd0, frame_err}, 32'd1);
    checkOutput("caperr_never_valid", {31'd0, valid_seen}, 32'd0);
    checkOutput("caperr_state", {30'd0, state}, 32'd3);

    // Restart from ERR with an edge landing in the same cycle as start: the edge is discarded.
    @(negedge sys_clk);
    data   = 1'b1;
    strobe = 1'b1;
    repeat (2) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    checkOutput("coincide_busy", {31'd0, busy}, 32'd1);
    checkOutput("coincide_bitcnt", {26'd0, dut.bit_cnt}, 32'd0);
    repeat (2) @(negedge sys_clk);
    strobe = 1'b0;
    repeat (4) @(negedge sys_clk);
    sendFrame(16'h1234, ^16'h1234, 1'b0);
    checkOutput("coincide_data", {16'd0, frame_data}, 32'h00001234);
    checkOutput("coincide_valid", {31'd0, frame_valid}, 32'd1);
    @(negedge sys_clk);
    frame_ready = 1'b1;
    @(negedge sys_clk);
    checkOutput("ready_held_valid", {31'd0, frame_valid}, 32'd0);

    // Ready held high permanently: frame leaves HOLD one cycle after valid rises.
    pulseStart();
    sendFrame(16'h8001, ^16'h8001, 1'b0);
    checkOutput("ready_held_state", {30'd0, state}, 32'd0);
    checkOutput("ready_held_data", {16'd0, frame_data}, 32'h00008001);
    frame_ready = 1'b0;

    // start in COLLECT restarts collection from scratch.
    pulseStart();
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    pulseStart();
    sendFrame(16'h0F0F, ^16'h0F0F, 1'b0);
    checkOutput("restart_data", {16'd0, frame_data}, 32'h00000F0F);
    frame_ready = 1'b1;
    @(negedge sys_clk);
    frame_ready = 1'b0;

`ifdef FRAME_PARITY_EN
    pulseStart();
    sendFrame(16'h0001, 1'b1, 1'b0);
    checkOutput("parity_ok_state", {30'd0, state}, 32'd2);
    frame_ready = 1'b1;
    @(negedge sys_clk);
    frame_ready = 1'b0;
    pulseStart();
    sendFrame(16'h0001, 1'b0, 1'b0);
    checkOutput("parity_bad_state", {30'd0, state}, 32'd3);
`endif

    // Reset held two cycles mid-collection discards everything.
    pulseStart();
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    @(negedge sys_clk);
    strobe  = 1'b1;
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    strobe  = 1'b0;
    sys_rst = 1'b1;
    checkOutput("midreset_outputs", {frame_data, frame_valid, frame_err, busy}, 32'd0);
    checkOutput("midreset_state", {30'd0, state}, 32'd0);
    checkOutput("midreset_bitcnt", {26'd0, dut.bit_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
